// File: rtl/secure_tdr.sv
// rtl/secure_tdr.sv - CRC-protected scan test data register with checked parallel update
// Frames are WIDTH data bits (LSB first) followed by a CRC-8/0x07 sent MSB first.
module secure_tdr #(
    parameter int              WIDTH     = 128,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             tck,
    input  logic             reset_n,
    input  logic             tdi,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic             update_en,
    input  logic [WIDTH-1:0] from_core,
    output logic [WIDTH-1:0] to_core,
    output logic             tdo,
    output logic             crc_ok,
    output logic             update_done,
    output logic             update_err,
    output logic             err_sticky
);

    localparam int             CW   = $clog2(WIDTH + 10);
    localparam logic [CW-1:0]  FULL = CW'(WIDTH + 8);
    localparam logic [CW-1:0]  OVER = CW'(WIDTH + 9);

    logic [WIDTH+7:0] sr;
    logic [CW-1:0]    count;
    logic [7:0]       crc;
    logic [7:0]       cap_crc;
    logic [7:0]       cap_sig;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Signature of the captured word, computed in the same order the bits leave tdo.
    always_comb begin
        cap_crc = 8'h00;
        for (int i = 0; i < WIDTH; i++) begin
            cap_crc = crc8_step(cap_crc, from_core[i]);
        end
        cap_sig = '0;
        for (int i = 0; i < 8; i++) begin
            cap_sig[i] = cap_crc[7-i];
        end
    end

    assign crc_ok = (count == FULL) && (crc == 8'h00);
    assign tdo    = sr[0];

    always_ff @(posedge tck) begin
        if (!reset_n) begin
            sr          <= '0;
            count       <= '0;
            crc         <= 8'h00;
            to_core     <= RESET_VAL;
            update_done <= 1'b0;
            update_err  <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            update_done <= 1'b0;
            update_err  <= 1'b0;
            if (capture_en) begin
                sr         <= {cap_sig, from_core};
                count      <= '0;
                crc        <= 8'h00;
                err_sticky <= 1'b0;
            end else if (shift_en) begin
                sr  <= {tdi, sr[WIDTH+7:1]};
                crc <= crc8_step(crc, tdi);
                if (count != OVER) begin
                    count <= count + 1'b1;
                end
            end else if (update_en) begin
                count <= '0;
                crc   <= 8'h00;
                if (crc_ok) begin
                    to_core     <= sr[WIDTH-1:0];
                    update_done <= 1'b1;
                end else begin
                    update_err <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule
